cobra_mem_arbiter: RTL and testbench

//  Shares the single-port system RAM between the tv80 CPU and the TV video fetch unit.

---
 rtl/cobra_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_cobra_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cobra_mem_arbiter.sv
// rtl/cobra_mem_arbiter.sv - CPU/video arbiter for the shared single-port system RAM
// Optional wait-cycle statistics counter enabled by defining COBRA_ARB_STATS_EN.
module cobra_mem_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
`ifdef COBRA_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_wait_cnt,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SW = $clog2(MAX_VID_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_VID_STREAK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              own_cpu_q, own_cpu_d;
    logic              we_q, we_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              grant_vid;

    // Video wins unless it has starved a waiting CPU for a full streak.
    assign grant_vid = vid_req & (~cpu_req | (streak_q < MAX_S));

    always_comb begin
        state_d     = state_q;
        own_cpu_d   = own_cpu_q;
        we_d        = we_q;
        streak_d    = streak_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (vid_req || cpu_req) begin
                    state_d  = S_ACC;
                    ram_en_d = 1'b1;
                    if (grant_vid) begin
                        own_cpu_d  = 1'b0;
                        we_d       = 1'b0;
                        ram_addr_d = vid_addr;
                        streak_d   = (streak_q == MAX_S) ? streak_q : streak_q + SW'(1);
                    end else begin
                        own_cpu_d   = 1'b1;
                        we_d        = cpu_we;
                        ram_we_d    = cpu_we;
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = cpu_wdata;
                        streak_d    = '0;
                    end
                end
            end
            S_ACC: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!we_q) begin
                    if (own_cpu_q) begin
                        cpu_rdata_d = ram_rdata;
                    end else begin
                        vid_rdata_d = ram_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            own_cpu_q   <= 1'b0;
            we_q        <= 1'b0;
            streak_q    <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_cpu_q   <= own_cpu_d;
            we_q        <= we_d;
            streak_q    <= streak_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign cpu_ack    = (state_q == S_DONE) & own_cpu_q;
    assign vid_ack    = (state_q == S_DONE) & ~own_cpu_q;
    // Read data is forwarded straight from the RAM in the ack cycle, then held.
    assign cpu_rdata  = (cpu_ack & ~we_q) ? ram_rdata : cpu_rdata_q;
    assign vid_rdata  = vid_ack ? ram_rdata : vid_rdata_q;
    assign cpu_wait_n = reset | ~(cpu_req & ~cpu_ack);

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

`ifdef COBRA_ARB_STATS_EN
    logic [15:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            wait_cnt_q <= '0;
        end else if (!cpu_wait_n && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    assign stat_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_cobra_mem_arbiter.sv
// tb/tb_cobra_mem_arbiter.sv - scoreboard bench for cobra_mem_arbiter with a RAM model
module tb_cobra_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_wait_n;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
`ifdef COBRA_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic preload;
    logic [7:0] mem [0:65535];
    logic [7:0] last_cpu_rd;

    typedef struct {
        bit         is_cpu;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[8];

    cobra_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_VID_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
`ifdef COBRA_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_wait_cnt(stat_wait_cnt),
`endif
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int a);
        if (a == 16'h1234) return 8'hA5;
        if (a == 16'h0010) return 8'h5A;
        if (a == 16'hFFFF) return 8'h77;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cpu_ack || vid_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, cpu_ack, vid_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", {30'd0, cpu_ack, vid_ack}, e.is_cpu ? 32'd2 : 32'd1);
                check("ack_cycle", cyc, e.cyc);
                check("ack_rdata", e.is_cpu ? cpu_rdata : vid_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_cpu, input logic [7:0] rdata, input int at);
        exp_t e;
        e.is_cpu = is_cpu;
        e.rdata  = rdata;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit is_cpu);
        bit ok = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (is_cpu ? cpu_ack : vid_ack) begin
                ok = 1;
                break;
            end
        end
        check("ack_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_xact(input vec_t v);
        if (v.is_cpu) begin
            cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            vid_req = 1; vid_addr = v.addr;
        end
        push(v.is_cpu, (v.is_cpu && v.we) ? last_cpu_rd : v.exp, cyc + 2);
        step();
        check("acc_ram_en", ram_en, 1);
        check("acc_ram_addr", ram_addr, v.addr);
        check("acc_ram_we", ram_we, v.is_cpu & v.we);
        if (v.is_cpu && v.we) check("acc_ram_wdata", ram_wdata, v.wdata);
        wait_ack(v.is_cpu);
        cpu_req = 0;
        vid_req = 0;
        if (v.is_cpu && !v.we) last_cpu_rd = v.exp;
        step();
        check("idle_ram_en", ram_en, 0);
        check("ack_one_cycle", {cpu_ack, vid_ack}, 0);
        if (v.is_cpu) check("cpu_rdata_hold", cpu_rdata, last_cpu_rd);
        else          check("vid_rdata_hold", vid_rdata, v.exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_v, got_c;
        int vcount;
        vecs[0] = '{1, 0, 16'h1234, 8'h00, 8'hA5};
        vecs[1] = '{1, 1, 16'h4000, 8'h3C, 8'h00};
        vecs[2] = '{1, 0, 16'h4000, 8'h00, 8'h3C};
        vecs[3] = '{0, 0, 16'h0010, 8'h00, 8'h5A};
        vecs[4] = '{1, 1, 16'h0000, 8'hFF, 8'h00};
        vecs[5] = '{0, 0, 16'h0000, 8'h00, 8'hFF};
        vecs[6] = '{0, 0, 16'hFFFF, 8'h00, 8'h77};
        vecs[7] = '{1, 0, 16'hFFFF, 8'h00, 8'h77};

        reset = 1; preload = 1; last_cpu_rd = 8'h00;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0;
`ifdef COBRA_ARB_STATS_EN
        stat_clr = 0;
`endif
        step(); step(); step();
        preload = 0;
        cpu_req = 1;
        #1;
        check("rst_wait_n", cpu_wait_n, 1);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_rdata", {cpu_rdata, vid_rdata}, 0);
        check("rst_acks", {cpu_ack, vid_ack}, 0);
        cpu_req = 0;
        step();
        reset = 0;
        step();

        for (int i = 0; i < 8; i++) do_xact(vecs[i]);

        // Simultaneous requests with streak at zero: video first, CPU three cycles later.
`ifdef COBRA_ARB_STATS_EN
        stat_clr = 1;
        step();
        stat_clr = 0;
        check("stat_cleared", stat_wait_cnt, 0);
`endif
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        vid_req = 1; vid_addr = 16'h0010;
        push(0, 8'h5A, cyc + 2);
        push(1, 8'hA5, cyc + 5);
        got_v = 0; got_c = 0;
        for (int i = 0; i < 20 && !(got_v && got_c); i++) begin
            step();
            if (vid_ack) begin vid_req = 0; got_v = 1; end
            if (cpu_ack) begin cpu_req = 0; got_c = 1; end
        end
        check("both_timeout", {30'd0, got_v, got_c}, 32'd3);
        last_cpu_rd = 8'hA5;
        step();
`ifdef COBRA_ARB_STATS_EN
        check("stat_wait_cnt", stat_wait_cnt, 5);
        stat_clr = 1;
        step();
        stat_clr = 0;
        check("stat_clr", stat_wait_cnt, 0);
`endif

        // Streak limit: four video grants, then the CPU, then video again.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        vid_req = 1; vid_addr = 16'h0010;
        push(0, 8'h5A, cyc + 2);
        push(0, 8'h5A, cyc + 5);
        push(0, 8'h5A, cyc + 8);
        push(0, 8'h5A, cyc + 11);
        push(1, 8'hA5, cyc + 14);
        push(0, 8'h5A, cyc + 17);
        vcount = 0; got_c = 0;
        for (int i = 0; i < 40 && !(vcount == 5 && got_c); i++) begin
            step();
            if (cpu_ack) begin cpu_req = 0; got_c = 1; end
            if (vid_ack) begin
                vcount++;
                if (vcount == 5) vid_req = 0;
            end
        end
        check("streak_vid_count", vcount, 5);
        check("streak_cpu_done", {31'd0, got_c}, 1);
        step();

        // Request withdrawn during ACC still completes and acks.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
        push(1, 8'h3C, cyc + 2);
        step();
        cpu_req = 0;
        wait_ack(1);
        last_cpu_rd = 8'h3C;
        step();

        // Reset during ACC abandons the read; a held request is redone afterwards.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        step();
        check("pre_rst_ram_en", ram_en, 1);
        reset = 1;
        #1;
        check("rst_mid_wait_n", cpu_wait_n, 1);
        step();
        check("rst_mid_ram_en", ram_en, 0);
        check("rst_mid_acks", {cpu_ack, vid_ack}, 0);
        check("rst_mid_rdata", cpu_rdata, 0);
        reset = 0;
        push(1, 8'hA5, cyc + 2);
        wait_ack(1);
        cpu_req = 0;
        step();
        check("post_rst_rdata_hold", cpu_rdata, 8'hA5);
        step(); step();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
